// File: rtl/freq_div_if.sv
// Divided-clock bundle produced by freq_div: three registered square waves
// in the system clock domain.
interface freq_div_if;
   logic clk_500Hz;
   logic clk_2Hz;
   logic clk_1Hz;

   modport master (output clk_500Hz, output clk_2Hz, output clk_1Hz);
   modport slave  (input  clk_500Hz, input  clk_2Hz, input  clk_1Hz);
endinterface

// File: rtl/freq_div.sv
// Free-running clock divider: three independent half-period counters, each
// with a toggle flop, giving 50%-duty square waves at FAST_HZ, MID_HZ and
// SLOW_HZ. All dividers share one reset, so their edges stay phase-aligned.
module freq_div #(
   parameter int CLK_FREQ_HZ = 40_000_000,
   parameter int FAST_HZ     = 500,
   parameter int MID_HZ      = 2,
   parameter int SLOW_HZ     = 1
) (
   input  logic       clk,
   input  logic       reset,
   freq_div_if.master div_if
);

   // Half-period lengths in system clock cycles (guarded against /0).
   localparam int HALF_FAST = (FAST_HZ > 0) ? CLK_FREQ_HZ / (2 * FAST_HZ) : 0;
   localparam int HALF_MID  = (MID_HZ  > 0) ? CLK_FREQ_HZ / (2 * MID_HZ)  : 0;
   localparam int HALF_SLOW = (SLOW_HZ > 0) ? CLK_FREQ_HZ / (2 * SLOW_HZ) : 0;

   // Counter widths: $clog2(HALF), never narrower than one bit.
   localparam int FAST_W = (HALF_FAST > 1) ? $clog2(HALF_FAST) : 1;
   localparam int MID_W  = (HALF_MID  > 1) ? $clog2(HALF_MID)  : 1;
   localparam int SLOW_W = (HALF_SLOW > 1) ? $clog2(HALF_SLOW) : 1;

   // Terminal counts, at which each counter wraps and its output toggles.
   localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(HALF_FAST - 1);
   localparam logic [MID_W-1:0]  MID_LAST  = MID_W'(HALF_MID - 1);
   localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(HALF_SLOW - 1);

   // A half-period that is not an exact positive integer would silently
   // skew the output frequency, so refuse to elaborate instead.
   if (FAST_HZ < 1 || HALF_FAST < 1 || (CLK_FREQ_HZ % (2 * FAST_HZ)) != 0) begin : g_bad_fast
      $error("freq_div: CLK_FREQ_HZ/(2*FAST_HZ) is not an integer >= 1");
   end
   if (MID_HZ < 1 || HALF_MID < 1 || (CLK_FREQ_HZ % (2 * MID_HZ)) != 0) begin : g_bad_mid
      $error("freq_div: CLK_FREQ_HZ/(2*MID_HZ) is not an integer >= 1");
   end
   if (SLOW_HZ < 1 || HALF_SLOW < 1 || (CLK_FREQ_HZ % (2 * SLOW_HZ)) != 0) begin : g_bad_slow
      $error("freq_div: CLK_FREQ_HZ/(2*SLOW_HZ) is not an integer >= 1");
   end

   logic [FAST_W-1:0] fast_cnt;
   logic [MID_W-1:0]  mid_cnt;
   logic [SLOW_W-1:0] slow_cnt;
   logic              fast_q;
   logic              mid_q;
   logic              slow_q;

   // Fast divider: count HALF_FAST cycles, then toggle clk_500Hz.
   always_ff @(posedge clk) begin
      if (reset) begin
         fast_cnt <= '0;
         fast_q   <= 1'b0;
      end else if (fast_cnt == FAST_LAST) begin
         fast_cnt <= '0;
         fast_q   <= ~fast_q;
      end else begin
         fast_cnt <= fast_cnt + 1'b1;
      end
   end

   // Mid divider: count HALF_MID cycles, then toggle clk_2Hz.
   always_ff @(posedge clk) begin
      if (reset) begin
         mid_cnt <= '0;
         mid_q   <= 1'b0;
      end else if (mid_cnt == MID_LAST) begin
         mid_cnt <= '0;
         mid_q   <= ~mid_q;
      end else begin
         mid_cnt <= mid_cnt + 1'b1;
      end
   end

   // Slow divider: count HALF_SLOW cycles, then toggle clk_1Hz.
   always_ff @(posedge clk) begin
      if (reset) begin
         slow_cnt <= '0;
         slow_q   <= 1'b0;
      end else if (slow_cnt == SLOW_LAST) begin
         slow_cnt <= '0;
         slow_q   <= ~slow_q;
      end else begin
         slow_cnt <= slow_cnt + 1'b1;
      end
   end

   // Outputs come straight from the toggle flops, so they are glitch-free.
   assign div_if.clk_500Hz = fast_q;
   assign div_if.clk_2Hz   = mid_q;
   assign div_if.clk_1Hz   = slow_q;

endmodule

// File: tb/tb_freq_div.sv
// Testbench for freq_div: a scaled instance (HALF = 2, 500, 1000) and a
// default-parameter instance, both checked every cycle against an
// edge-count model, plus directed checks at hand-computed edges.
module tb_freq_div;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   edges = 0;       // rising edges with reset low since last reset
   bit   cmp_en = 1'b0;

   freq_div_if sc_if ();
   freq_div_if df_if ();

   freq_div #(
      .CLK_FREQ_HZ(2000),
      .FAST_HZ    (500),
      .MID_HZ     (2),
      .SLOW_HZ    (1)
   ) u_scaled (
      .clk   (clk),
      .reset (reset),
      .div_if(sc_if)
   );

   freq_div u_default (
      .clk   (clk),
      .reset (reset),
      .div_if(df_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t edge=%0d: got %b expected %b", name, $time, edges, act, exp);
      end
   endtask

   // Model: after e rising edges out of reset, a divider with half-period H
   // has toggled floor(e/H) times, starting from 0.
   function automatic logic model_out(input int e, input int half);
      return ((e / half) % 2) == 1;
   endfunction

   always @(posedge clk) begin
      if (reset) edges = 0;
      else       edges = edges + 1;
      cmp_en = 1'b1;
   end

   // Continuous comparison on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_fast", sc_if.clk_500Hz, model_out(edges, 2));
         chk("m_mid",  sc_if.clk_2Hz,   model_out(edges, 500));
         chk("m_slow", sc_if.clk_1Hz,   model_out(edges, 1000));
         chk("m_def_fast", df_if.clk_500Hz, model_out(edges, 40_000));
         chk("m_def_mid",  df_if.clk_2Hz,   model_out(edges, 10_000_000));
         chk("m_def_slow", df_if.clk_1Hz,   model_out(edges, 20_000_000));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held for 5 edges: every output low on every edge.
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("rst_fast", sc_if.clk_500Hz, 1'b0);
         chk("rst_mid",  sc_if.clk_2Hz,   1'b0);
         chk("rst_slow", sc_if.clk_1Hz,   1'b0);
      end
      reset = 1'b0;

      // Fast divider: rise on edge 2, fall on 4, rise on 6.
      step(1); chk("fast_e1", sc_if.clk_500Hz, 1'b0);
      step(1); chk("fast_e2", sc_if.clk_500Hz, 1'b1);
      step(1); chk("fast_e3", sc_if.clk_500Hz, 1'b1);
      step(1); chk("fast_e4", sc_if.clk_500Hz, 1'b0);
      step(2); chk("fast_e6", sc_if.clk_500Hz, 1'b1);

      // Slow dividers.
      step(493); chk("mid_e499", sc_if.clk_2Hz, 1'b0);
      step(1);   chk("mid_e500", sc_if.clk_2Hz, 1'b1);
      step(499); chk("mid_e999", sc_if.clk_2Hz, 1'b1);
                 chk("slow_e999", sc_if.clk_1Hz, 1'b0);
      step(1);   chk("mid_e1000", sc_if.clk_2Hz, 1'b0);
                 chk("slow_e1000", sc_if.clk_1Hz, 1'b1);
      step(500); chk("mid_e1500", sc_if.clk_2Hz, 1'b1);
                 chk("slow_e1500", sc_if.clk_1Hz, 1'b1);
      step(500); chk("mid_e2000", sc_if.clk_2Hz, 1'b0);
                 chk("slow_e2000", sc_if.clk_1Hz, 1'b0);

      // Restart from a fresh reset, then a one-edge reset at edge 750.
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(749); chk("mid_e749", sc_if.clk_2Hz, 1'b1);
      reset = 1'b1;
      step(1);
      chk("mrst_fast", sc_if.clk_500Hz, 1'b0);
      chk("mrst_mid",  sc_if.clk_2Hz,   1'b0);
      chk("mrst_slow", sc_if.clk_1Hz,   1'b0);
      reset = 1'b0;
      step(499); chk("mid_rel499", sc_if.clk_2Hz, 1'b0);
      step(1);   chk("mid_rel500", sc_if.clk_2Hz, 1'b1);
                 chk("def_fast_idle", df_if.clk_500Hz, 1'b0);
      step(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
